// File: rtl/gal_vector_sweeper.sv
// ---------------------------------------------------------------------------
// gal_vector_sweeper
//
// Exhaustive stimulus/response engine for combinational programmable-logic
// models (e.g. GAL22V10_io). Drives every input vector 0 .. 2^IN_WIDTH-1 on I.
// Each vector is held for SETTLE_CYCLES+1 cycles, and the device response IOQ
// is sampled on the final edge of that window. Every sample is folded into a
// 16-bit MISR, so the whole truth table reduces to one signature word.
//
// Optional feature macro: GAL_SWEEP_STB_EN
//   When defined, two per-vector logging outputs are added:
//     STB - high during each SAMPLE cycle.
//     CAP - the IOQ value registered on that SAMPLE edge.
//   The signature behaviour is the same with or without the macro.
//
// Parameters:
//   IN_WIDTH       stimulus width
//   OUT_WIDTH      response width (<= 16)
//   SETTLE_CYCLES  hold cycles before the sample cycle (>= 1)
//   SIG_SEED       MISR value loaded on reset and on START
//   SIG_POLY       MISR feedback polynomial
//
// Ports:
//   CLK    in   clock, rising edge
//   RST    in   asynchronous active-high reset
//   START  in   begin a sweep (only acted on in IDLE)
//   I      out  stimulus vector to the device
//   IOQ    in   device response
//   BUSY   out  high while sweeping
//   DONE   out  high from sweep completion until the next START or reset
//   SIG    out  MISR signature
//   STB    out  (GAL_SWEEP_STB_EN only) sample strobe
//   CAP    out  (GAL_SWEEP_STB_EN only) captured response
// ---------------------------------------------------------------------------
module gal_vector_sweeper #(
    parameter int          IN_WIDTH      = 12,
    parameter int          OUT_WIDTH     = 10,
    parameter int          SETTLE_CYCLES = 4,
    parameter logic [15:0] SIG_SEED      = 16'hFFFF,
    parameter logic [15:0] SIG_POLY      = 16'h1021
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic [IN_WIDTH-1:0]  I,
    input  logic [OUT_WIDTH-1:0] IOQ,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [15:0]          SIG
`ifdef GAL_SWEEP_STB_EN
    ,
    output logic                 STB,
    output logic [OUT_WIDTH-1:0] CAP
`endif
);

    // The counter only has to reach SETTLE_CYCLES-1. It is kept at least
    // 1 bit wide so that SETTLE_CYCLES=1 still elaborates.
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [IN_WIDTH-1:0]  r_vec;
    logic [15:0]          r_sig;
    logic                 r_done;

    state_t               w_nstate;
    logic [CNT_W-1:0]     w_cnt;
    logic [IN_WIDTH-1:0]  w_vec;
    logic [15:0]          w_sig;
    logic                 w_done;
    logic [15:0]          w_ioq_ext;
    logic [15:0]          w_sig_step;

    // IOQ is data only: any X/Z on it is allowed to reach the signature.
    assign w_ioq_ext  = 16'(IOQ);
    assign w_sig_step = ({r_sig[14:0], 1'b0} ^ (r_sig[15] ? SIG_POLY : 16'h0000))
                        ^ w_ioq_ext;

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nstate;
        end
    end

    // Next-state and datapath next values
    always_comb begin
        w_nstate = r_state;
        w_cnt    = r_cnt;
        w_vec    = r_vec;
        w_sig    = r_sig;
        w_done   = r_done;
        case (r_state)
            ST_IDLE: begin
                if (START) begin
                    w_nstate = ST_SETTLE;
                    w_vec    = '0;
                    w_sig    = SIG_SEED;
                    w_cnt    = '0;
                    w_done   = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (r_cnt == CNT_LAST) begin
                    w_nstate = ST_SAMPLE;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            ST_SAMPLE: begin
                w_sig = w_sig_step;
                // Stop on the last vector instead of wrapping. I is left at all-ones.
                if (&r_vec) begin
                    w_done   = 1'b1;
                    w_nstate = ST_IDLE;
                end else begin
                    w_vec    = r_vec + 1'b1;
                    w_cnt    = '0;
                    w_nstate = ST_SETTLE;
                end
            end
            default: begin
                w_nstate = ST_IDLE;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt  <= '0;
            r_vec  <= '0;
            r_sig  <= SIG_SEED;
            r_done <= 1'b0;
        end else begin
            r_cnt  <= w_cnt;
            r_vec  <= w_vec;
            r_sig  <= w_sig;
            r_done <= w_done;
        end
    end

    assign I    = r_vec;
    assign SIG  = r_sig;
    assign DONE = r_done;
    assign BUSY = (r_state != ST_IDLE);

`ifdef GAL_SWEEP_STB_EN
    logic [OUT_WIDTH-1:0] r_cap;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cap <= '0;
        end else if (r_state == ST_SAMPLE) begin
            r_cap <= IOQ;
        end
    end

    assign STB = (r_state == ST_SAMPLE);
    assign CAP = r_cap;
`endif

endmodule

// File: tb/tb_gal_vector_sweeper.sv
// Directed bench for gal_vector_sweeper. It uses three instances:
//   A: IN=12 OUT=10 SETTLE=2 SEED=0      - full zero sweep, table of MISR steps
//   B: defaults, IOQ = identity(I[9:0])  - reset, START-ignore, mid-sweep RST,
//                                          loop-back signature, STB/CAP
//   C: IN=4 OUT=4 SETTLE=3 SEED=FFFF     - window length, IOQ glitch immunity
module tb_gal_vector_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] misr(input logic [15:0] s, input logic [15:0] d,
                                         input logic [15:0] poly);
        return ({s[14:0], 1'b0} ^ (s[15] ? poly : 16'h0000)) ^ d;
    endfunction

    // ---------------- instance A ----------------
    logic        rst_a, start_a, busy_a, done_a;
    logic [11:0] i_a;
    logic [9:0]  ioq_a;
    logic [15:0] sig_a;
`ifdef GAL_SWEEP_STB_EN
    logic        stb_a;
    logic [9:0]  cap_a;
`endif
    gal_vector_sweeper #(.IN_WIDTH(12), .OUT_WIDTH(10), .SETTLE_CYCLES(2),
                         .SIG_SEED(16'h0000), .SIG_POLY(16'h1021)) u_a (
        .CLK(clk), .RST(rst_a), .START(start_a), .I(i_a), .IOQ(ioq_a),
        .BUSY(busy_a), .DONE(done_a), .SIG(sig_a)
`ifdef GAL_SWEEP_STB_EN
        , .STB(stb_a), .CAP(cap_a)
`endif
    );

    // ---------------- instance B (loop-back) ----------------
    logic        rst_b, start_b, busy_b, done_b;
    logic [11:0] i_b;
    logic [9:0]  ioq_b;
    logic [15:0] sig_b;
`ifdef GAL_SWEEP_STB_EN
    logic        stb_b;
    logic [9:0]  cap_b;
`endif
    // Reference device: identity on the low 10 input pins.
    assign ioq_b = i_b[9:0];
    gal_vector_sweeper u_b (
        .CLK(clk), .RST(rst_b), .START(start_b), .I(i_b), .IOQ(ioq_b),
        .BUSY(busy_b), .DONE(done_b), .SIG(sig_b)
`ifdef GAL_SWEEP_STB_EN
        , .STB(stb_b), .CAP(cap_b)
`endif
    );

    // ---------------- instance C ----------------
    logic        rst_c, start_c, busy_c, done_c;
    logic [3:0]  i_c;
    logic [3:0]  ioq_c;
    logic [15:0] sig_c;
`ifdef GAL_SWEEP_STB_EN
    logic        stb_c;
    logic [3:0]  cap_c;
`endif
    gal_vector_sweeper #(.IN_WIDTH(4), .OUT_WIDTH(4), .SETTLE_CYCLES(3),
                         .SIG_SEED(16'hFFFF), .SIG_POLY(16'h1021)) u_c (
        .CLK(clk), .RST(rst_c), .START(start_c), .I(i_c), .IOQ(ioq_c),
        .BUSY(busy_c), .DONE(done_c), .SIG(sig_c)
`ifdef GAL_SWEEP_STB_EN
        , .STB(stb_c), .CAP(cap_c)
`endif
    );

`ifdef GAL_SWEEP_STB_EN
    // Per-vector log of B: the n-th strobe must capture identity(n).
    logic       log_en = 1'b0;
    logic       cap_pend = 1'b0;
    logic [9:0] cap_exp = '0;
    int         stb_cnt = 0;
    int         cap_bad = 0;
    always @(negedge clk) begin
        if (log_en) begin
            if (cap_pend) begin
                if (cap_b !== cap_exp) cap_bad <= cap_bad + 1;
                cap_pend <= 1'b0;
            end
            if (stb_b === 1'b1) begin
                cap_exp  <= stb_cnt[9:0];
                stb_cnt  <= stb_cnt + 1;
                cap_pend <= 1'b1;
            end
        end
    end
`endif

    typedef struct {
        logic [9:0]  ioq;
        logic [11:0] exp_i;
        logic [15:0] exp_sig;
    } vec_t;

    vec_t        tbl [6];
    int          cnt;
    logic [15:0] model;
    logic [3:0]  good;

    initial begin
        // MISR steps from seed 0. Hand-computed: shift left, poly if bit15, xor IOQ.
        tbl[0] = '{10'h001, 12'h000, 16'h0001};
        tbl[1] = '{10'h001, 12'h001, 16'h0003};
        tbl[2] = '{10'h001, 12'h002, 16'h0007};
        tbl[3] = '{10'h3FF, 12'h003, 16'h03F1};
        tbl[4] = '{10'h200, 12'h004, 16'h05E2};
        tbl[5] = '{10'h000, 12'h005, 16'h0BC4};

        rst_a = 0; rst_b = 0; rst_c = 0;
        start_a = 0; start_b = 0; start_c = 0;
        ioq_a = '0; ioq_c = '0;

        // Asynchronous reset applied between clock edges
        #7;
        rst_a = 1; rst_b = 1; rst_c = 1;
        #1;
        check("rst_I",    i_b,    0);
        check("rst_SIG",  sig_b,  16'hFFFF);
        check("rst_BUSY", busy_b, 0);
        check("rst_DONE", done_b, 0);
        check("rst_SIG_seed0", sig_a, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst_a = 0; rst_b = 0; rst_c = 0;
        @(negedge clk);

        // ---- C: each vector held 4 cycles; only the last-cycle IOQ counts ----
        start_c = 1;
        @(negedge clk);
        start_c = 0;
        check("C_start_BUSY", busy_c, 1);
        model = 16'hFFFF;
        for (int v = 0; v < 16; v++) begin
            good = 4'(v) ^ 4'hA;
            for (int c = 0; c < 4; c++) begin
                check($sformatf("C_I_v%0d_c%0d", v, c), i_c, 32'(v));
                ioq_c = (c == 3) ? good : (good ^ 4'($urandom_range(1, 15)));
                @(negedge clk);
            end
            model = misr(model, 16'(good), 16'h1021);
            check($sformatf("C_SIG_v%0d", v), sig_c, model);
        end
        check("C_DONE", done_c, 1);
        check("C_BUSY_end", busy_c, 0);
        check("C_I_end", i_c, 4'hF);

        // ---- A: IOQ tied 0, seed 0 -> BUSY 12288 cycles, SIG 0 ----
        ioq_a = '0;
        start_a = 1;
        @(negedge clk);
        start_a = 0;
        check("A_start_I", i_a, 0);
        cnt = 0;
        while (busy_a === 1'b1 && cnt < 13000) begin
            cnt++;
            @(negedge clk);
        end
        check("A_busy_cycles", cnt, 12288);
        check("A_DONE", done_a, 1);
        check("A_SIG_zero", sig_a, 16'h0000);
        check("A_I_final", i_a, 12'hFFF);
        @(negedge clk);
        check("A_DONE_held", done_a, 1);
        check("A_I_held", i_a, 12'hFFF);

        // ---- A: restart from the completed state, table of MISR steps ----
        start_a = 1;
        @(negedge clk);
        start_a = 0;
        check("A_restart_DONE", done_a, 0);
        check("A_restart_BUSY", busy_a, 1);
        for (int r = 0; r < 6; r++) begin
            ioq_a = tbl[r].ioq;
            check($sformatf("A_tbl%0d_I", r), i_a, tbl[r].exp_i);
            repeat (3) @(negedge clk);
            check($sformatf("A_tbl%0d_SIG", r), sig_a, tbl[r].exp_sig);
        end

        // ---- A: reset and START together, reset wins ----
        rst_a = 1;
        start_a = 1;
        @(negedge clk);
        check("A_rst_start_BUSY", busy_a, 0);
        check("A_rst_start_I", i_a, 0);
        check("A_rst_start_SIG", sig_a, 16'h0000);
        rst_a = 0;
        start_a = 0;
        @(negedge clk);
        check("A_idle_after_rst", busy_a, 0);

        // ---- B: START ignored at vector 100, RST at vector 200 ----
        start_b = 1;
        @(negedge clk);
        start_b = 0;
        cnt = 0;
        while (i_b !== 12'd100 && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
        check("B_reach_100", i_b, 100);
        cnt = 0;
        start_b = 1;
        @(negedge clk);
        cnt++;
        start_b = 0;
        check("B_start_ignored_I", i_b, 100);
        check("B_start_ignored_BUSY", busy_b, 1);
        while (i_b !== 12'd200 && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
        check("B_100_to_200_cycles", cnt, 500);
        rst_b = 1;
        #1;
        check("B_midrst_I", i_b, 0);
        check("B_midrst_BUSY", busy_b, 0);
        check("B_midrst_DONE", done_b, 0);
        check("B_midrst_SIG", sig_b, 16'hFFFF);
        @(negedge clk);
        rst_b = 0;
        @(negedge clk);
        check("B_idle_after_rst", busy_b, 0);
        check("B_no_partial_DONE", done_b, 0);

        // ---- B: fresh full loop-back sweep ----
`ifdef GAL_SWEEP_STB_EN
        log_en = 1'b1;
`endif
        start_b = 1;
        @(negedge clk);
        start_b = 0;
        check("B_fresh_I", i_b, 0);
        check("B_fresh_BUSY", busy_b, 1);
        cnt = 0;
        while (busy_b === 1'b1 && cnt < 21000) begin
            cnt++;
            @(negedge clk);
        end
        check("B_busy_cycles", cnt, 20480);
        model = 16'hFFFF;
        for (int v = 0; v < 4096; v++) begin
            model = misr(model, {6'b0, 10'(v)}, 16'h1021);
        end
        check("B_DONE", done_b, 1);
        check("B_SIG_loopback", sig_b, model);
        check("B_I_final", i_b, 12'hFFF);
        @(negedge clk);
`ifdef GAL_SWEEP_STB_EN
        log_en = 1'b0;
        check("B_STB_count", stb_cnt, 4096);
        check("B_CAP_bad", cap_bad, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/gal_vector_sweeper.md
# gal_vector_sweeper

Self-checking stimulus/response engine for programmable-logic models. It sweeps every input vector into a combinational device such as `GAL22V10_io`, waits a programmable settle time, and samples the device outputs. Samples are compacted into a 16-bit MISR signature, so the full truth table is reduced to one comparable word. The block sits directly upstream of the device's `I` pins and directly downstream of its `IOQ` pins, and is used in benches and on-board self-test.

## Interface
Parameters:
- `IN_WIDTH`, 12: width of stimulus vector driven to device inputs.
- `OUT_WIDTH`, 10: width of sampled device outputs; must be ≤ 16.
- `SETTLE_CYCLES`, 4: cycles each vector is held before sampling; must be ≥ 1.
- `SIG_SEED`, 16'hFFFF: MISR value loaded on reset and on `START`.
- `SIG_POLY`, 16'h1021: MISR feedback polynomial.

Ports:
- `CLK`  in  1  sole clock, rising edge.
- `RST`  in  1  reset; asynchronous, active-high.
- `START`  in  1  begin sweep; honoured only in IDLE.
- `I`  out  IN_WIDTH  stimulus vector to device.
- `IOQ`  in  OUT_WIDTH  device response.
- `BUSY`  out  1  high while sweeping.
- `DONE`  out  1  high from sweep completion until next `START` or reset.
- `SIG`  out  16  MISR signature.

## Operation
States:
- IDLE: the idle and completed state. `BUSY` is 0.
  - `START`=1 → load `I`=0, `SIG`=`SIG_SEED`, settle count=0, clear `DONE`, go to SETTLE.
- SETTLE: hold `I`; settle count increments by 1 each cycle.
  - When count = `SETTLE_CYCLES`-1 → go to SAMPLE.
- SAMPLE: lasts one cycle. Update `SIG` = ({SIG[14:0],1'b0} ^ (SIG[15] ? SIG_POLY : 0)) ^ zero-extended `IOQ`.
  - If `I` = all-ones → set `DONE`, go to IDLE. `I` stays at all-ones.
  - Otherwise → `I`=`I`+1, count=0, go to SETTLE.
- `I` increment is modulo 2^IN_WIDTH, but the sweep terminates before wrap.
- `START` while `BUSY` is ignored. `START` held high in IDLE after `DONE` restarts a sweep on the next edge.
- `IOQ` is treated as data only; X/Z on `IOQ` propagates into `SIG` and is not masked.

## Timing
- Reset values (asynchronous on `RST` rise, held while `RST`=1):
  - `I`=0, `SIG`=`SIG_SEED`, `BUSY`=0, `DONE`=0, state IDLE, count=0.
- `START` sampled high at edge k:
  - from edge k: `I`=0 and `BUSY`=1.
  - `DONE`=1 and `BUSY`=0 at edge k + 2^IN_WIDTH × (SETTLE_CYCLES+1).
- Each vector is held for exactly SETTLE_CYCLES+1 cycles. `IOQ` is sampled on the final edge of that window.
- `SIG` changes only on SAMPLE edges, reset, and `START` edges.
- `RST` mid-sweep: immediate return to IDLE with reset values. No partial `DONE`.
- `RST` and `START` asserted together: reset wins.

## Configuration
- `GAL_SWEEP_STB_EN` defined:
  - adds output `STB` (1 bit): one-cycle pulse coincident with each SAMPLE cycle.
  - adds output `CAP` (OUT_WIDTH): `IOQ` registered on that SAMPLE edge, reset 0.
  - used for per-vector logging.
- Not defined: `STB` and `CAP` are absent. Signature behaviour is identical either way.

## Test plan
- Reset: assert `RST` mid-cycle, no clock edge → `I`=0, `SIG`=16'hFFFF, `BUSY`=0, `DONE`=0 immediately.
- Settings `SIG_SEED`=0, `IOQ` tied 0, `SETTLE_CYCLES`=2; pulse `START` → `BUSY` high for exactly 12288 cycles, then `DONE`=1, `SIG`=16'h0000, `I`=12'hFFF.
- Settings `SIG_SEED`=0, `IOQ`=10'h001, `SETTLE_CYCLES`=1 → `SIG` after 1st, 2nd, 3rd SAMPLE = 16'h0001, 16'h0003, 16'h0007.
- `SETTLE_CYCLES`=3 → `I` steps 0,1,2,… with each value stable for exactly 4 cycles. `IOQ` changes in the first 3 cycles of a window do not affect `SIG`.
- Pulse `START` at vector 100 → ignored, sweep unchanged. Assert `RST` at vector 200 → IDLE, `DONE`=0, and a fresh `START` restarts at `I`=0.
- Loop-back with `GAL22V10_io` programmed as identity on `I[9:0]` → final `SIG` matches the bench reference MISR model. With `GAL_SWEEP_STB_EN`, 4096 `STB` pulses occur and each `CAP` equals the reference output.
